md_unit: RTL and testbench

//   Multi-cycle multiply/divide unit; sits beside the single-cycle ALU in the E stage.

---
 rtl/md_unit.sv | 185 ++++++++++++++++++
 tb/tb_md_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with private HI/LO registers.
// Results are computed at accept and released to HI/LO after a fixed latency.
module md_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mdop,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] shi_q, shi_d;
    logic [WIDTH-1:0] slo_q, slo_d;
    logic             swr_q, swr_d;

    logic is_mul, is_div, is_mthi, is_mtlo, is_arith;
    logic accept, last;

    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH-1:0]   q_mag, r_mag;
    logic [WIDTH-1:0]   q_s, r_s, q_u, r_u;
    logic               b_zero;

    // Decode the requested operation class
    always_comb begin
        is_mul  = 1'b0;
        is_div  = 1'b0;
        is_mthi = 1'b0;
        is_mtlo = 1'b0;
        unique case (mdop)
            OP_MULT, OP_MULTU: is_mul  = 1'b1;
            OP_DIV, OP_DIVU:   is_div  = 1'b1;
            OP_MTHI:           is_mthi = 1'b1;
            OP_MTLO:           is_mtlo = 1'b1;
            default:           ;
        endcase
    end

    assign is_arith = is_mul | is_div;
    assign accept   = start & (state_q == S_IDLE);
    assign last     = (cnt_q == CW'(1));

    // Arithmetic: signed division runs on magnitudes so MIN/-1 needs no special case
    always_comb begin
        prod_s = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
        prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
        b_zero = (B == '0);
        abs_a  = A[WIDTH-1] ? (~A + 1'b1) : A;
        abs_b  = B[WIDTH-1] ? (~B + 1'b1) : B;
        q_mag  = '0;
        r_mag  = '0;
        q_u    = '0;
        r_u    = '0;
        if (!b_zero) begin
            q_mag = abs_a / abs_b;
            r_mag = abs_a % abs_b;
            q_u   = A / B;
            r_u   = A % B;
        end
        q_s = (A[WIDTH-1] ^ B[WIDTH-1]) ? (~q_mag + 1'b1) : q_mag;
        r_s = A[WIDTH-1] ? (~r_mag + 1'b1) : r_mag;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: idle until an arithmetic op is accepted, busy until count expires
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept && is_arith) state_d = S_BUSY;
            S_BUSY: if (last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: busy from state, stall also covers the accepting cycle
    always_comb begin
        busy  = (state_q == S_BUSY);
        stall = busy | (start & is_arith);
        hi    = hi_q;
        lo    = lo_q;
    end

    // Datapath next values: counter, shadows and HI/LO commit
    always_comb begin
        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        shi_d = shi_q;
        slo_d = slo_q;
        swr_d = swr_q;
        if (state_q == S_BUSY) begin
            cnt_d = cnt_q - CW'(1);
            if (last && swr_q) begin
                hi_d = shi_q;
                lo_d = slo_q;
            end
        end else if (accept) begin
            unique case (mdop)
                OP_MULT: begin
                    shi_d = prod_s[2*WIDTH-1:WIDTH];
                    slo_d = prod_s[WIDTH-1:0];
                    swr_d = 1'b1;
                    cnt_d = CW'(MUL_CYCLES);
                end
                OP_MULTU: begin
                    shi_d = prod_u[2*WIDTH-1:WIDTH];
                    slo_d = prod_u[WIDTH-1:0];
                    swr_d = 1'b1;
                    cnt_d = CW'(MUL_CYCLES);
                end
                OP_DIV: begin
                    shi_d = r_s;
                    slo_d = q_s;
                    swr_d = ~b_zero;
                    cnt_d = CW'(DIV_CYCLES);
                end
                OP_DIVU: begin
                    shi_d = r_u;
                    slo_d = q_u;
                    swr_d = ~b_zero;
                    cnt_d = CW'(DIV_CYCLES);
                end
                OP_MTHI: hi_d = A;
                OP_MTLO: lo_d = A;
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            shi_q <= '0;
            slo_q <= '0;
            swr_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            shi_q <= shi_d;
            slo_q <= slo_d;
            swr_q <= swr_d;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed testbench for md_unit.
// Each scenario task drives stimulus and checks HI/LO/busy/stall inline.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int total;
    int passed;
    int n;

    md_unit #(
        .WIDTH(32),
        .MUL_CYCLES(5),
        .DIV_CYCLES(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .mdop(mdop),
        .A(A),
        .B(B),
        .busy(busy),
        .stall(stall),
        .hi(hi),
        .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present an op on the negedge, let it be accepted at posedge, sample #1 later
    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        mdop  = op;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        mdop  = 3'd0;
    endtask

    // Count sampled busy cycles starting just after the accept edge; bounded
    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 50) begin
            cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        mdop  = 3'd0;
        A     = '0;
        B     = '0;
        #12;
        total++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || stall !== 1'b0)
            $display("FAIL reset_state busy=%b stall=%b hi=%h lo=%h expected 0/0/0/0",
                     busy, stall, hi, lo);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mult;
        launch(3'd1, 32'hFFFF_FFFF, 32'd2);
        total++;
        if (busy !== 1'b1 || hi !== 32'h0 || lo !== 32'h0)
            $display("FAIL mult_launch busy=%b hi=%h lo=%h expected 1/0/0", busy, hi, lo);
        else passed++;
        wait_idle(n);
        total++;
        if (n !== 5) $display("FAIL mult_busy_cycles got %0d expected 5", n);
        else passed++;
        total++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE)
            $display("FAIL mult_result hi=%h lo=%h expected ffffffff/fffffffe", hi, lo);
        else passed++;
    endtask

    task automatic test_multu_ignore;
        launch(3'd2, 32'hFFFF_FFFF, 32'd2);
        // request during busy must be ignored
        @(negedge clk);
        start = 1'b1;
        mdop  = 3'd1;
        A     = 32'd3;
        B     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        mdop  = 3'd0;
        A     = 32'h1111_1111;
        wait_idle(n);
        total++;
        if (n !== 4) $display("FAIL multu_busy_cycles got %0d expected 4 remaining", n);
        else passed++;
        total++;
        if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE)
            $display("FAIL multu_result hi=%h lo=%h expected 00000001/fffffffe", hi, lo);
        else passed++;
    endtask

    task automatic test_div;
        launch(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        total++;
        if (n !== 10) $display("FAIL div_busy_cycles got %0d expected 10", n);
        else passed++;
        total++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD)
            $display("FAIL div_result hi=%h lo=%h expected ffffffff/fffffffd", hi, lo);
        else passed++;
        // next op accepted in the same cycle the result becomes visible
        launch(3'd4, 32'd7, 32'd2);
        wait_idle(n);
        total++;
        if (hi !== 32'd1 || lo !== 32'd3 || n !== 10)
            $display("FAIL divu_result hi=%h lo=%h cycles=%0d expected 1/3/10", hi, lo, n);
        else passed++;
    endtask

    task automatic test_div_edge;
        launch(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        total++;
        if (hi !== 32'h0 || lo !== 32'h8000_0000)
            $display("FAIL div_overflow hi=%h lo=%h expected 0/80000000", hi, lo);
        else passed++;
        launch(3'd4, 32'd5, 32'd0);
        wait_idle(n);
        total++;
        if (n !== 10) $display("FAIL divzero_busy_cycles got %0d expected 10", n);
        else passed++;
        total++;
        if (hi !== 32'h0 || lo !== 32'h8000_0000)
            $display("FAIL divzero_keep hi=%h lo=%h expected 0/80000000", hi, lo);
        else passed++;
        launch(3'd3, 32'd9, 32'd0);
        wait_idle(n);
        total++;
        if (hi !== 32'h0 || lo !== 32'h8000_0000)
            $display("FAIL sdivzero_keep hi=%h lo=%h expected 0/80000000", hi, lo);
        else passed++;
    endtask

    task automatic test_mthi_mtlo;
        @(negedge clk);
        start = 1'b1;
        mdop  = 3'd5;
        A     = 32'h1234;
        total++;
        if (stall !== 1'b0) $display("FAIL mthi_stall got %b expected 0", stall);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || hi !== 32'h1234)
            $display("FAIL mthi busy=%b hi=%h expected 0/1234", busy, hi);
        else passed++;
        mdop = 3'd6;
        A    = 32'h5678;
        @(posedge clk);
        #1;
        start = 1'b0;
        mdop  = 3'd0;
        total++;
        if (busy !== 1'b0 || hi !== 32'h1234 || lo !== 32'h5678)
            $display("FAIL mtlo busy=%b hi=%h lo=%h expected 0/1234/5678", busy, hi, lo);
        else passed++;
        // start with NONE op changes nothing
        @(negedge clk);
        start = 1'b1;
        mdop  = 3'd7;
        A     = 32'hDEAD;
        @(posedge clk);
        #1;
        start = 1'b0;
        mdop  = 3'd0;
        total++;
        if (busy !== 1'b0 || hi !== 32'h1234 || lo !== 32'h5678)
            $display("FAIL none_op busy=%b hi=%h lo=%h expected 0/1234/5678", busy, hi, lo);
        else passed++;
    endtask

    task automatic test_stall;
        @(negedge clk);
        start = 1'b1;
        mdop  = 3'd1;
        A     = 32'd6;
        B     = 32'd7;
        #1;
        total++;
        if (stall !== 1'b1 || busy !== 1'b0)
            $display("FAIL stall_comb stall=%b busy=%b expected 1/0", stall, busy);
        else passed++;
        @(posedge clk);
        #1;
        start = 1'b0;
        mdop  = 3'd0;
        total++;
        if (stall !== 1'b1 || busy !== 1'b1)
            $display("FAIL stall_busy stall=%b busy=%b expected 1/1", stall, busy);
        else passed++;
        wait_idle(n);
        total++;
        if (hi !== 32'h0 || lo !== 32'd42 || stall !== 1'b0)
            $display("FAIL stall_mult hi=%h lo=%h stall=%b expected 0/2a/0", hi, lo, stall);
        else passed++;
    endtask

    task automatic test_reset_mid;
        launch(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1) $display("FAIL pre_reset_busy got %b expected 1", busy);
        else passed++;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0)
            $display("FAIL reset_mid busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0)
            $display("FAIL reset_discard busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
        else passed++;
        launch(3'd1, 32'hFFFF_FFFD, 32'd4);
        wait_idle(n);
        total++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF4 || n !== 5)
            $display("FAIL post_reset_mult hi=%h lo=%h cycles=%0d expected ffffffff/fffffff4/5",
                     hi, lo, n);
        else passed++;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        test_reset();
        test_mult();
        test_multu_ignore();
        test_div();
        test_div_edge();
        test_mthi_mtlo();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
